// File: rtl/muldiv_if.sv
// Bus between the RV32M multi-cycle sequencer and the EX stage.
// Carries the request, result and shared-ALU signals; clk and rst stay separate.
interface muldiv_if #(parameter int WIDTH = 32);
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] src_b;
   logic             flush;
   logic             stall;
   logic             done;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [4:0]       alu_op;
   logic [WIDTH-1:0] alu_out;

   modport slave (
      input  start, op, src_a, src_b, flush, alu_out,
      output stall, done, result, alu_a, alu_b, alu_op
   );

   modport master (
      output start, op, src_a, src_b, flush, alu_out,
      input  stall, done, result, alu_a, alu_b, alu_op
   );
endinterface

// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M MUL/DIV/DIVU/REM/REMU sequencer.
// Borrows the EX-stage ALU for one add or sub per cycle while stall is high.
module muldiv_seq #(
   parameter int WIDTH = 32
) (
   input  logic     clk,
   input  logic     rst,
   muldiv_if.slave  bus
);
   localparam logic [4:0] ALU_OP_NOP = 5'd0;
   localparam logic [4:0] ALU_OP_ADD = 5'd1;
   localparam logic [4:0] ALU_OP_SUB = 5'd2;
   localparam logic [4:0] LAST_ITER  = 5'(WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PREP = 3'd1,
      S_LOOP = 3'd2,
      S_FIX  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t      state_r;
   state_t      state_s;
   logic [2:0]  op_r;
   logic [31:0] a_r;
   logic [31:0] b_r;
   logic [31:0] acc_r;
   logic [31:0] x_r;
   logic [31:0] y_r;
   logic [31:0] result_r;
   logic [4:0]  cnt_r;
   logic        neg_q_r;
   logic        neg_rem_r;
   logic        stall_r;
   logic        done_r;

   logic        is_mul_s;
   logic        is_div_s;
   logic        is_signed_s;
   logic [31:0] abs_a_s;
   logic [31:0] abs_b_s;
   logic [32:0] pr_s;
   logic        ge_s;
   logic [31:0] fix_s;
   logic [31:0] alu_a_s;
   logic [31:0] alu_b_s;
   logic [4:0]  alu_op_s;

   function automatic logic [31:0] neg32(input logic [31:0] v);
      return ~v + 32'd1;
   endfunction

   // x_r holds multiplicand or divisor; y_r holds multiplier or dividend/quotient
   assign is_mul_s    = (op_r == 3'b000);
   assign is_div_s    = op_r[2];
   assign is_signed_s = op_r[2] & ~op_r[0];
   assign abs_a_s     = (is_signed_s && a_r[31]) ? neg32(a_r) : a_r;
   assign abs_b_s     = (is_signed_s && b_r[31]) ? neg32(b_r) : b_r;
   assign pr_s        = {acc_r, y_r[31]};
   assign ge_s        = (pr_s >= {1'b0, x_r});

   assign bus.stall  = stall_r;
   assign bus.done   = done_r;
   assign bus.result = result_r;
   assign bus.alu_a  = alu_a_s;
   assign bus.alu_b  = alu_b_s;
   assign bus.alu_op = alu_op_s;

   // Next-state decode; flush aborts any busy state back to idle.
   always_comb begin
      state_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (bus.start) state_s = S_PREP;
            else           state_s = S_IDLE;
         end
         S_PREP: begin
            if (bus.flush) state_s = S_IDLE;
            else           state_s = S_LOOP;
         end
         S_LOOP: begin
            if (bus.flush)               state_s = S_IDLE;
            else if (cnt_r == LAST_ITER) state_s = S_FIX;
            else                         state_s = S_LOOP;
         end
         S_FIX: begin
            if (bus.flush) state_s = S_IDLE;
            else           state_s = S_DONE;
         end
         S_DONE:  state_s = S_IDLE;
         default: state_s = S_IDLE;
      endcase
   end

   // Shared-ALU request, only driven during the iteration loop.
   always_comb begin
      alu_a_s  = 32'd0;
      alu_b_s  = 32'd0;
      alu_op_s = ALU_OP_NOP;
      if (state_r == S_LOOP) begin
         if (is_mul_s) begin
            if (y_r[0]) begin
               alu_a_s  = acc_r;
               alu_b_s  = x_r;
               alu_op_s = ALU_OP_ADD;
            end else begin
               alu_op_s = ALU_OP_NOP;
            end
         end else if (is_div_s) begin
            alu_a_s  = pr_s[31:0];
            alu_b_s  = x_r;
            alu_op_s = ALU_OP_SUB;
         end else begin
            alu_op_s = ALU_OP_NOP;
         end
      end else begin
         alu_op_s = ALU_OP_NOP;
      end
   end

   // Sign fix-up of the final quotient or remainder.
   always_comb begin
      fix_s = 32'd0;
      if (is_mul_s) begin
         fix_s = acc_r;
      end else if (is_div_s) begin
         if (op_r[1]) fix_s = neg_rem_r ? neg32(acc_r) : acc_r;
         else         fix_s = neg_q_r ? neg32(y_r) : y_r;
      end else begin
         fix_s = 32'd0;
      end
   end

   // State, handshake outputs and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= S_IDLE;
         op_r      <= 3'd0;
         a_r       <= 32'd0;
         b_r       <= 32'd0;
         acc_r     <= 32'd0;
         x_r       <= 32'd0;
         y_r       <= 32'd0;
         result_r  <= 32'd0;
         cnt_r     <= 5'd0;
         neg_q_r   <= 1'b0;
         neg_rem_r <= 1'b0;
         stall_r   <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         state_r <= state_s;
         stall_r <= (state_s == S_PREP) || (state_s == S_LOOP) || (state_s == S_FIX);
         done_r  <= (state_s == S_DONE);
         case (state_r)
            S_IDLE: begin
               if (bus.start) begin
                  op_r <= bus.op;
                  a_r  <= bus.src_a;
                  b_r  <= bus.src_b;
               end
            end
            S_PREP: begin
               acc_r     <= 32'd0;
               cnt_r     <= 5'd0;
               neg_q_r   <= is_signed_s & (a_r[31] ^ b_r[31]) & (b_r != 32'd0);
               neg_rem_r <= is_signed_s & a_r[31];
               x_r       <= is_mul_s ? a_r : abs_b_s;
               y_r       <= is_mul_s ? b_r : abs_a_s;
            end
            S_LOOP: begin
               cnt_r <= cnt_r + 5'd1;
               if (is_mul_s) begin
                  if (y_r[0]) acc_r <= bus.alu_out;
                  x_r <= {x_r[30:0], 1'b0};
                  y_r <= {1'b0, y_r[31:1]};
               end else if (is_div_s) begin
                  acc_r <= ge_s ? bus.alu_out : pr_s[31:0];
                  y_r   <= {y_r[30:0], ge_s};
               end
            end
            S_FIX: begin
               if (!bus.flush) result_r <= fix_s;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed scoreboard bench for muldiv_seq with a behavioural EX-stage ALU.
module tb_muldiv_seq;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   muldiv_if bus ();
   muldiv_seq dut (.clk(clk), .rst(rst), .bus(bus));

   // EX-stage ALU: nop=0, add=1, sub=2
   assign bus.alu_out = (bus.alu_op == 5'd1) ? bus.alu_a + bus.alu_b :
                        (bus.alu_op == 5'd2) ? bus.alu_a - bus.alu_b : 32'd0;

   int pass_cnt  = 0;
   int total_cnt = 0;
   logic [31:0] exp_q[$];
   logic [31:0] last_result = 32'd0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Monitor: every done pulse must match the oldest expected result
   always @(negedge clk) begin
      if (bus.done === 1'b1) begin
         if (exp_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
         else check("result", bus.result, exp_q.pop_front());
      end
   end

   task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp, input bit hold, input string name);
      int n;
      int stall_cnt;
      bit seen;
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = op;
      bus.src_a = a;
      bus.src_b = b;
      exp_q.push_back(exp);
      last_result = exp;
      @(posedge clk);
      #1;
      if (!hold) bus.start = 1'b0;
      stall_cnt = bus.stall ? 1 : 0;
      n = 0;
      seen = 1'b0;
      while (n < 60 && !seen) begin
         @(posedge clk);
         #1;
         n++;
         if (bus.done) seen = 1'b1;
         else if (bus.stall) stall_cnt++;
      end
      bus.start = 1'b0;
      check({name, "_latency"}, 32'(n), 32'd34);
      check({name, "_stall_cycles"}, 32'(stall_cnt), 32'd34);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      bus.start = 1'b0;
      bus.op    = 3'd0;
      bus.src_a = 32'd0;
      bus.src_b = 32'd0;
      bus.flush = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_stall", {31'd0, bus.stall}, 32'd0);
      check("rst_done", {31'd0, bus.done}, 32'd0);
      check("rst_result", bus.result, 32'd0);
      check("rst_alu_op", {27'd0, bus.alu_op}, 32'd0);
      rst = 1'b0;

      run(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, "mul_neg");
      run(3'b000, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 1'b0, "mul_shift");
      run(3'b101, 32'd100, 32'd7, 32'd14, 1'b0, "divu");
      run(3'b111, 32'd100, 32'd7, 32'd2, 1'b0, "remu");
      run(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, "rem_neg");
      run(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, "div_neg");
      run(3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0, "div_by0");
      run(3'b110, 32'd5, 32'd0, 32'd5, 1'b0, "rem_by0");
      run(3'b100, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 1'b0, "div_neg_by0");
      run(3'b110, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1'b0, "rem_neg_by0");
      run(3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0, "divu_by0");
      run(3'b111, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1'b0, "remu_by0");
      run(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, "div_ovf");
      run(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, "rem_ovf");
      run(3'b001, 32'd9, 32'd3, 32'd0, 1'b0, "unsupported");
      run(3'b101, 32'd1000, 32'd10, 32'd100, 1'b0, "divu_prev");

      // flush at loop iteration 10
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = 3'b101;
      bus.src_a = 32'd77;
      bus.src_b = 32'd5;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (11) @(posedge clk);
      #1;
      bus.flush = 1'b1;
      @(posedge clk);
      #1;
      bus.flush = 1'b0;
      check("flush_stall", {31'd0, bus.stall}, 32'd0);
      check("flush_done", {31'd0, bus.done}, 32'd0);
      check("flush_result_kept", bus.result, last_result);
      run(3'b000, 32'd3, 32'd4, 32'd12, 1'b0, "mul_after_flush");

      // synchronous reset at loop iteration 20
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = 3'b000;
      bus.src_a = 32'd5;
      bus.src_b = 32'd6;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (21) @(posedge clk);
      #1;
      check("loop_alu_busy", {31'd0, bus.stall}, 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("mid_rst_stall", {31'd0, bus.stall}, 32'd0);
      check("mid_rst_done", {31'd0, bus.done}, 32'd0);
      check("mid_rst_result", bus.result, 32'd0);
      check("mid_rst_alu_op", {27'd0, bus.alu_op}, 32'd0);

      run(3'b100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b1, "div_start_held");

      repeat (5) @(posedge clk);
      #1;
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
